// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the PCF8563 transaction sequencer.
//   - byte-lane offsets of the 56-bit time word {sec,min,hour,day,wday,cent_month,year}
//   - per-field masks applied before range checking
//   - sequencer state and operation enums
//   - small BCD helper functions
package rtc_pkg;

   localparam int unsigned SEC_HI   = 55;
   localparam int unsigned SEC_LO   = 48;
   localparam int unsigned MIN_HI   = 47;
   localparam int unsigned MIN_LO   = 40;
   localparam int unsigned HOUR_HI  = 39;
   localparam int unsigned HOUR_LO  = 32;
   localparam int unsigned DAY_HI   = 31;
   localparam int unsigned DAY_LO   = 24;
   localparam int unsigned WDAY_HI  = 23;
   localparam int unsigned WDAY_LO  = 16;
   localparam int unsigned MONTH_HI = 15;
   localparam int unsigned MONTH_LO = 8;
   localparam int unsigned YEAR_HI  = 7;
   localparam int unsigned YEAR_LO  = 0;

   // Bit 7 of sec is the VL flag; bit 7 of cent_month is the century flag.
   localparam logic [7:0] SEC_MASK   = 8'h7F;
   localparam logic [7:0] MIN_MASK   = 8'h7F;
   localparam logic [7:0] HOUR_MASK  = 8'h3F;
   localparam logic [7:0] DAY_MASK   = 8'h3F;
   localparam logic [7:0] WDAY_MASK  = 8'h07;
   localparam logic [7:0] MONTH_MASK = 8'h1F;
   localparam logic [7:0] CENT_MASK  = 8'h80;
   localparam logic [7:0] YEAR_MASK  = 8'hFF;

   typedef enum logic [1:0] {IDLE, PULSE, WAIT, CAPTURE} state_t;
   typedef enum logic {GET, SET} op_t;

   function automatic logic bcd_byte_ok(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   // With both nibbles valid, BCD compares correctly as plain binary.
   function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (b >= lo) && (b <= hi);
   endfunction

endpackage

// File: rtl/rtc_scheduler_if.sv
// rtc_scheduler_if: host-side and engine-side signals of the RTC sequencer.
//   host:   refresh_en, host_get_req, host_set_req, host_set_data -> scheduler
//           host_busy, host_data, host_valid, host_err, host_vl   <- scheduler
//   engine: rtc_get, rtc_set, rtc_in <- scheduler; rtc_out -> scheduler
//   slave modport is the scheduler; master modport is the surrounding system.
interface rtc_scheduler_if;

   logic        refresh_en;
   logic        host_get_req;
   logic        host_set_req;
   logic [55:0] host_set_data;
   logic        host_busy;
   logic [55:0] host_data;
   logic        host_valid;
   logic        host_err;
   logic        host_vl;
   logic        rtc_get;
   logic        rtc_set;
   logic [55:0] rtc_in;
   logic [55:0] rtc_out;

   modport slave (
      input  refresh_en, host_get_req, host_set_req, host_set_data, rtc_out,
      output host_busy, host_data, host_valid, host_err, host_vl, rtc_get, rtc_set, rtc_in
   );

   modport master (
      output refresh_en, host_get_req, host_set_req, host_set_data, rtc_out,
      input  host_busy, host_data, host_valid, host_err, host_vl, rtc_get, rtc_set, rtc_in
   );

endinterface

// File: rtl/rtc_bcd_check.sv
// rtc_bcd_check: combinational validation of a PCF8563 time word.
//   raw    in  56  {sec,min,hour,day,wday,cent_month,year} as read from the engine
//   masked out 56  fields with unused/flag bits cleared; century bit kept in cent_month
//   ok     out 1   every masked nibble is BCD and every field is in calendar range
module rtc_bcd_check
   import rtc_pkg::*;
(
   input  logic [55:0] raw,
   output logic [55:0] masked,
   output logic        ok
);

   logic [7:0] sec, mins, hour, day, wday, month, cent, year;

   always_comb begin
      sec   = raw[SEC_HI:SEC_LO] & SEC_MASK;
      mins  = raw[MIN_HI:MIN_LO] & MIN_MASK;
      hour  = raw[HOUR_HI:HOUR_LO] & HOUR_MASK;
      day   = raw[DAY_HI:DAY_LO] & DAY_MASK;
      wday  = raw[WDAY_HI:WDAY_LO] & WDAY_MASK;
      month = raw[MONTH_HI:MONTH_LO] & MONTH_MASK;
      cent  = raw[MONTH_HI:MONTH_LO] & CENT_MASK;
      year  = raw[YEAR_HI:YEAR_LO] & YEAR_MASK;

      masked = {sec, mins, hour, day, wday, month | cent, year};

      ok = bcd_byte_ok(sec) && bcd_byte_ok(mins) && bcd_byte_ok(hour) &&
           bcd_byte_ok(day) && bcd_byte_ok(wday) && bcd_byte_ok(month) &&
           bcd_byte_ok(year) &&
           in_range(sec, 8'h00, 8'h59) && in_range(mins, 8'h00, 8'h59) &&
           in_range(hour, 8'h00, 8'h23) && in_range(day, 8'h01, 8'h31) &&
           in_range(wday, 8'h00, 8'h06) && in_range(month, 8'h01, 8'h12) &&
           in_range(year, 8'h00, 8'h99);
   end

endmodule

// File: rtl/rtc_scheduler.sv
// rtc_scheduler: serialises host set/get requests and periodic refresh reads into
// single strobed transactions for the PCF8563 engine, which has no done signal.
// Each transaction is a PULSE_CYCLES strobe followed by a guard window totalling
// XFER_CYCLES from strobe start; reads then capture rtc_out through a BCD check.
//   mclk   in  system clock
//   reset  in  asynchronous active-high reset
//   bus    rtc_scheduler_if.slave: host request/status and engine strobe/data signals
module rtc_scheduler
   import rtc_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 28000000,
   parameter int unsigned XFER_CYCLES    = 65536,
   parameter int unsigned PULSE_CYCLES   = 4
) (
   input logic            mclk,
   input logic            reset,
   rtc_scheduler_if.slave bus
);

   localparam int unsigned TW = $clog2(XFER_CYCLES + 1);
   localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [TW-1:0] PULSE_LAST     = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] XFER_LAST      = TW'(XFER_CYCLES - 1);
   localparam logic [RW-1:0] REFRESH_RELOAD = RW'(REFRESH_CYCLES - 1);

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] refresh_q, refresh_d;
   logic          refresh_hit;
   logic          set_pend_q, set_pend_d;
   logic          get_pend_q, get_pend_d;
   logic [55:0]   shadow_q, shadow_d;
   logic [55:0]   rtc_in_q;
   logic [55:0]   host_data_q;
   logic          host_valid_q, host_err_q, host_vl_q;

   logic          busy, get_strobe, set_strobe;
   logic          issue_set, issue_get, xfer_done, capture;
   logic [55:0]   chk_masked;
   logic          chk_ok;

   rtc_bcd_check u_bcd_check (
      .raw    (bus.rtc_out),
      .masked (chk_masked),
      .ok     (chk_ok)
   );

   // FSM state register; reset drops the strobes asynchronously.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (set_pend_q || get_pend_q) state_d = PULSE;
         PULSE:   if (timer_q == PULSE_LAST) state_d = WAIT;
         WAIT:    if (timer_q == XFER_LAST) state_d = (op_q == SET) ? IDLE : CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and datapath controls
   always_comb begin
      busy       = (state_q != IDLE);
      get_strobe = (state_q == PULSE) && (op_q == GET);
      set_strobe = (state_q == PULSE) && (op_q == SET);
      issue_set  = (state_q == IDLE) && set_pend_q;
      issue_get  = (state_q == IDLE) && !set_pend_q && get_pend_q;
      xfer_done  = (state_q == WAIT) && (timer_q == XFER_LAST);
      capture    = (state_q == CAPTURE);
   end

   // Datapath next state. Consumption is applied before new requests so that a
   // request landing on the consuming cycle stays pending.
   always_comb begin
      timer_d = timer_q;
      if (issue_set || issue_get) begin
         timer_d = '0;
      end else if ((state_q == PULSE) || (state_q == WAIT)) begin
         timer_d = timer_q + TW'(1);
      end

      op_d = op_q;
      if (issue_set) begin
         op_d = SET;
      end else if (issue_get) begin
         op_d = GET;
      end

      refresh_hit = bus.refresh_en && (refresh_q == '0);
      refresh_d   = refresh_q;
      if (bus.refresh_en) begin
         refresh_d = refresh_hit ? REFRESH_RELOAD : refresh_q - RW'(1);
      end

      set_pend_d = set_pend_q;
      if (issue_set) set_pend_d = 1'b0;
      if (bus.host_set_req) set_pend_d = 1'b1;

      // A completed write always schedules a read-back.
      get_pend_d = get_pend_q;
      if (issue_get) get_pend_d = 1'b0;
      if (bus.host_get_req || refresh_hit || (xfer_done && (op_q == SET))) get_pend_d = 1'b1;

      shadow_d = bus.host_set_req ? bus.host_set_data : shadow_q;
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         op_q         <= GET;
         timer_q      <= '0;
         refresh_q    <= REFRESH_RELOAD;
         set_pend_q   <= 1'b0;
         get_pend_q   <= 1'b0;
         shadow_q     <= '0;
         rtc_in_q     <= '0;
         host_data_q  <= '0;
         host_valid_q <= 1'b0;
         host_err_q   <= 1'b0;
         host_vl_q    <= 1'b0;
      end else begin
         op_q       <= op_d;
         timer_q    <= timer_d;
         refresh_q  <= refresh_d;
         set_pend_q <= set_pend_d;
         get_pend_q <= get_pend_d;
         shadow_q   <= shadow_d;
         if (issue_set) rtc_in_q <= shadow_q;
         if (capture) begin
            host_vl_q <= bus.rtc_out[SEC_HI];
            if (chk_ok) begin
               host_data_q  <= chk_masked;
               host_valid_q <= 1'b1;
               host_err_q   <= 1'b0;
            end else begin
               host_err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.host_busy  = busy;
   assign bus.host_data  = host_data_q;
   assign bus.host_valid = host_valid_q;
   assign bus.host_err   = host_err_q;
   assign bus.host_vl    = host_vl_q;
   assign bus.rtc_get    = get_strobe;
   assign bus.rtc_set    = set_strobe;
   assign bus.rtc_in     = rtc_in_q;

endmodule

// File: tb/tb_rtc_scheduler.sv
// tb_rtc_scheduler: directed self-checking bench for rtc_scheduler with a short
// guard window and refresh period.
module tb_rtc_scheduler;

   localparam int REFRESH = 1000;
   localparam int XFER    = 64;
   localparam int PULSE   = 4;

   localparam logic [55:0] V1 = 56'h30_45_12_15_03_08_24;
   localparam logic [55:0] S1 = 56'h00_00_00_01_00_01_25;
   localparam logic [55:0] S2 = 56'h80_00_00_01_00_81_99;
   localparam logic [55:0] S2_MASKED = 56'h00_00_00_01_00_81_99;

   logic mclk  = 1'b0;
   logic reset = 1'b1;

   rtc_scheduler_if bus ();

   rtc_scheduler #(
      .REFRESH_CYCLES (REFRESH),
      .XFER_CYCLES    (XFER),
      .PULSE_CYCLES   (PULSE)
   ) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 mclk = ~mclk;

   int checks = 0;
   int errors = 0;

   // Strobe monitor
   int          cyc = 0;
   int          get_cnt = 0, set_cnt = 0;
   int          get_run = 0, set_run = 0;
   int          get_len = 0, set_len = 0;
   int          get_rise_cyc = 0;
   int          en_cnt = 0, en_at_rise = 0;
   logic        get_prev = 1'b0, set_prev = 1'b0, overlap = 1'b0;
   logic [55:0] rtc_in_at_set = '0;

   always @(posedge mclk) begin
      if (bus.refresh_en) en_cnt <= en_cnt + 1;
   end

   always @(negedge mclk) begin
      cyc      <= cyc + 1;
      get_prev <= bus.rtc_get;
      set_prev <= bus.rtc_set;
      if (bus.rtc_get && !get_prev) begin
         get_cnt      <= get_cnt + 1;
         get_rise_cyc <= cyc;
         en_at_rise   <= en_cnt;
      end
      if (bus.rtc_set && !set_prev) begin
         set_cnt       <= set_cnt + 1;
         rtc_in_at_set <= bus.rtc_in;
      end
      if (bus.rtc_get) get_run <= get_run + 1;
      else begin
         if (get_prev) get_len <= get_run;
         get_run <= 0;
      end
      if (bus.rtc_set) set_run <= set_run + 1;
      else begin
         if (set_prev) set_len <= set_run;
         set_run <= 0;
      end
      if (bus.rtc_get && bus.rtc_set) overlap <= 1'b1;
   end

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [55:0] obs, input logic [55:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic get_req();
      bus.host_get_req = 1'b1;
      @(negedge mclk);
      bus.host_get_req = 1'b0;
   endtask

   task automatic set_req(input logic [55:0] d);
      bus.host_set_data = d;
      bus.host_set_req  = 1'b1;
      @(negedge mclk);
      bus.host_set_req  = 1'b0;
   endtask

   // Waits for busy to rise, then counts the sampled busy cycles until it falls.
   task automatic wait_txn(input string tag, output int n);
      int w;
      w = 0;
      n = 0;
      while (!bus.host_busy && w < 50) begin
         @(negedge mclk);
         w++;
      end
      while (bus.host_busy && n < 5000) begin
         n++;
         @(negedge mclk);
      end
      check_int({tag, "_end"}, int'(bus.host_busy), 0);
   endtask

   task automatic wait_get_rise(input string tag, input int budget);
      int w, c;
      w = 0;
      c = get_cnt;
      while (get_cnt == c && w < budget) begin
         @(negedge mclk);
         w++;
      end
      check_int({tag, "_rise"}, int'(get_cnt != c), 1);
   endtask

   logic [55:0] bad_vec [5] = '{56'h85_45_25_15_03_08_24, 56'h00_00_00_15_03_08_9A,
                                56'h00_00_00_00_00_01_25, 56'h00_00_00_01_00_13_25,
                                56'h00_00_00_01_07_01_25};
   int          bad_vl  [5] = '{1, 0, 0, 0, 0};

   initial begin
      int   n, g0, s0, t1, t2, e2, c;
      logic bad;

      bus.refresh_en    = 1'b0;
      bus.host_get_req  = 1'b0;
      bus.host_set_req  = 1'b0;
      bus.host_set_data = '0;
      bus.rtc_out       = '0;
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      reset = 1'b0;

      check_int("rst_busy", int'(bus.host_busy), 0);
      check_val("rst_data", bus.host_data, '0);
      check_int("rst_valid", int'(bus.host_valid), 0);
      check_int("rst_err", int'(bus.host_err), 0);
      check_int("rst_vl", int'(bus.host_vl), 0);
      check_int("rst_get", int'(bus.rtc_get), 0);
      check_int("rst_set", int'(bus.rtc_set), 0);
      check_val("rst_rtc_in", bus.rtc_in, '0);

      bad = 1'b0;
      repeat (10000) begin
         @(negedge mclk);
         if (bus.host_busy || bus.rtc_get || bus.rtc_set || bus.host_valid || bus.host_err ||
             bus.host_vl || (|bus.host_data) || (|bus.rtc_in)) bad = 1'b1;
      end
      check_int("quiet_outputs", int'(bad), 0);
      check_int("quiet_strobes", get_cnt + set_cnt, 0);

      // Host read
      g0 = get_cnt;
      s0 = set_cnt;
      bus.rtc_out = V1;
      get_req();
      wait_txn("get1", n);
      check_int("get1_busy_cycles", n, XFER + 1);
      check_int("get1_pulse_len", get_len, PULSE);
      check_int("get1_get_count", get_cnt - g0, 1);
      check_int("get1_set_count", set_cnt - s0, 0);
      check_val("get1_data", bus.host_data, V1);
      check_int("get1_valid", int'(bus.host_valid), 1);
      check_int("get1_err", int'(bus.host_err), 0);
      check_int("get1_vl", int'(bus.host_vl), 0);

      // Host write with automatic read-back
      g0 = get_cnt;
      s0 = set_cnt;
      bus.rtc_out = S1;
      set_req(S1);
      wait_txn("set1", n);
      check_int("set1_busy_cycles", n, XFER);
      check_int("set1_pulse_len", set_len, PULSE);
      check_val("set1_rtc_in_at_strobe", rtc_in_at_set, S1);
      check_int("set1_set_count", set_cnt - s0, 1);
      check_int("set1_no_get_yet", get_cnt - g0, 0);
      wait_txn("rb1", n);
      check_int("rb1_busy_cycles", n, XFER + 1);
      check_int("rb1_get_count", get_cnt - g0, 1);
      check_val("rb1_data", bus.host_data, S1);
      check_val("rb1_rtc_in_held", bus.rtc_in, S1);

      // Simultaneous set and get: set first, one merged get
      g0 = get_cnt;
      s0 = set_cnt;
      bus.rtc_out       = S2;
      bus.host_set_data = S2;
      bus.host_set_req  = 1'b1;
      bus.host_get_req  = 1'b1;
      @(negedge mclk);
      bus.host_set_req  = 1'b0;
      bus.host_get_req  = 1'b0;
      wait_txn("both_set", n);
      check_int("both_set_busy_cycles", n, XFER);
      check_int("both_set_first", get_cnt - g0, 0);
      wait_txn("both_get", n);
      check_int("both_get_busy_cycles", n, XFER + 1);
      repeat (200) @(negedge mclk);
      check_int("both_get_count", get_cnt - g0, 1);
      check_int("both_set_count", set_cnt - s0, 1);
      check_val("both_data_masked", bus.host_data, S2_MASKED);
      check_int("both_vl", int'(bus.host_vl), 1);
      check_int("both_err", int'(bus.host_err), 0);

      // Failing captures leave host_data alone
      for (int i = 0; i < 5; i++) begin
         bus.rtc_out = bad_vec[i];
         get_req();
         wait_txn($sformatf("bad%0d", i), n);
         check_int($sformatf("bad%0d_err", i), int'(bus.host_err), 1);
         check_int($sformatf("bad%0d_vl", i), int'(bus.host_vl), bad_vl[i]);
         check_val($sformatf("bad%0d_data_kept", i), bus.host_data, S2_MASKED);
         check_int($sformatf("bad%0d_valid", i), int'(bus.host_valid), 1);
      end

      // Upper-limit fields with masked-off hour bits recover the error flag
      bus.rtc_out = 56'h59_59_63_31_06_12_99;
      get_req();
      wait_txn("max", n);
      check_int("max_err", int'(bus.host_err), 0);
      check_val("max_data", bus.host_data, 56'h59_59_23_31_06_12_99);

      // Repeated set requests before issue: last write wins
      g0 = get_cnt;
      s0 = set_cnt;
      bus.rtc_out = V1;
      get_req();
      repeat (5) @(negedge mclk);
      set_req(56'h11_22_13_04_05_06_07);
      repeat (3) @(negedge mclk);
      set_req(56'h00_30_09_28_02_02_26);
      wait_txn("lww_get", n);
      wait_txn("lww_set", n);
      check_int("lww_set_busy_cycles", n, XFER);
      check_val("lww_rtc_in_at_strobe", rtc_in_at_set, 56'h00_30_09_28_02_02_26);
      wait_txn("lww_rb", n);
      check_int("lww_set_count", set_cnt - s0, 1);
      check_int("lww_get_count", get_cnt - g0, 2);
      check_val("lww_data", bus.host_data, V1);

      // Periodic refresh, hold and resume
      bus.refresh_en = 1'b1;
      wait_get_rise("ref1", 1200);
      t1 = get_rise_cyc;
      wait_get_rise("ref2", 1200);
      t2 = get_rise_cyc;
      e2 = en_at_rise;
      check_int("refresh_period", t2 - t1, REFRESH);
      repeat (300) @(negedge mclk);
      bus.refresh_en = 1'b0;
      c = get_cnt;
      repeat (3000) @(negedge mclk);
      check_int("refresh_hold", get_cnt - c, 0);
      bus.refresh_en = 1'b1;
      wait_get_rise("ref3", 1200);
      check_int("refresh_resume_enabled_cycles", en_at_rise - e2, REFRESH);
      check_int("refresh_resume_wall_cycles", get_rise_cyc - t2, REFRESH + 3000);
      bus.refresh_en = 1'b0;
      wait_txn("ref3", n);

      // Reset during the strobe
      get_req();
      c = 0;
      while (!bus.rtc_get && c < 10) begin
         @(negedge mclk);
         c++;
      end
      check_int("rstp_strobe_seen", int'(bus.rtc_get), 1);
      reset = 1'b1;
      #1;
      check_int("rstp_get", int'(bus.rtc_get), 0);
      check_int("rstp_busy", int'(bus.host_busy), 0);
      @(negedge mclk);
      reset = 1'b0;

      // Reset during the guard window with a write pending
      get_req();
      repeat (20) @(negedge mclk);
      check_int("rstw_in_wait", int'(bus.host_busy && !bus.rtc_get), 1);
      set_req(S1);
      repeat (2) @(negedge mclk);
      reset = 1'b1;
      #1;
      check_int("rstw_busy", int'(bus.host_busy), 0);
      check_int("rstw_strobes", int'(bus.rtc_get || bus.rtc_set), 0);
      check_int("rstw_valid", int'(bus.host_valid), 0);
      check_val("rstw_data", bus.host_data, '0);
      @(negedge mclk);
      reset = 1'b0;
      g0 = get_cnt;
      s0 = set_cnt;
      repeat (300) @(negedge mclk);
      check_int("rstw_pend_cleared", (get_cnt - g0) + (set_cnt - s0), 0);

      check_int("no_overlap", int'(overlap), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_scheduler.md
Name: rtc_scheduler

Overview:
Sequencer in front of the PCF8563 I2C RTC engine. The engine has only edge-triggered rtc_get/rtc_set strobes and no completion signal. This block arbitrates host set/get requests and a periodic refresh timer into one transaction at a time, then waits a fixed guard window. It captures rtc_out into a BCD-validated shadow register for the host, and sits between the host/SPI command decoder and the RTC engine.

Parameters:
REFRESH_CYCLES, 28000000, mclk cycles between automatic reads (1 s at 28 MHz).
XFER_CYCLES, 65536, guard window in mclk cycles from strobe assertion to capture; covers the worst-case engine transaction.
PULSE_CYCLES, 4, high time of the rtc_get/rtc_set strobe; must be at least 2.

Ports:
mclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
refresh_en  in  1  enables periodic reads
host_get_req  in  1  one-cycle read request
host_set_req  in  1  one-cycle write request
host_set_data  in  56  {sec,min,hour,day,wday,cent_month,year}, BCD
host_busy  out  1  transaction in flight
host_data  out  56  last valid captured time
host_valid  out  1  host_data holds at least one valid capture
host_err  out  1  last capture failed BCD/range check
host_vl  out  1  VL bit (sec[7]) of last capture
rtc_get  out  1  read strobe to engine
rtc_set  out  1  write strobe to engine
rtc_in  out  56  write data to engine, held stable until the next accepted set
rtc_out  in  56  engine read result, stable after the guard window

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags clear; refresh counter = REFRESH_CYCLES-1.
- Pending flags: set_pend, get_pend.
  - host_set_req: set_pend=1 and shadow_set=host_set_data. A repeat request before issue overwrites the shadow (last write wins).
  - host_get_req or refresh expiry: get_pend=1. Requests while already pending merge.
- Refresh counter decrements only when refresh_en=1. At 0 it raises get_pend and reloads REFRESH_CYCLES-1. With refresh_en=0 it holds its value.
- States:
  - IDLE: if set_pend, load rtc_in=shadow_set, clear set_pend, go PULSE with op=SET. Else if get_pend, clear get_pend, go PULSE with op=GET. Set has priority over get.
  - PULSE: the strobe for op is high for PULSE_CYCLES; then go WAIT.
  - WAIT: timer counts to XFER_CYCLES measured from PULSE entry. If op=SET, set get_pend (automatic read-back) and return to IDLE; no capture. If op=GET, go CAPTURE.
  - CAPTURE: one cycle. Validate rtc_out and update outputs, then go IDLE.
- host_busy=1 in every state except IDLE.
- A request arriving the same cycle IDLE consumes a flag is latched for the next transaction; a request is never lost.
- Validation (masks before checking):
  - sec & 7F ≤ 59; min & 7F ≤ 59; hour & 3F ≤ 23.
  - day & 3F in 1..31; wday & 07 ≤ 6; cent_month & 1F in 1..12; year ≤ 99.
  - Every nibble ≤ 9.
- On pass: host_data = masked fields, with cent_month keeping bit 7 (century); host_valid=1; host_err=0.
- On fail: host_data unchanged; host_err=1. host_vl = rtc_out[55] in both cases.
- Strobes never overlap; a new strobe only begins from IDLE, so there is at least one idle cycle after each guard window.
- Asynchronous reset mid-transaction: strobes drop immediately and pending flags clear. The engine is not aborted by this block; the engine has its own reset.

Decomposition:
- Package rtc_pkg holds:
  - byte-lane offset constants (SEC_HI=55 … YEAR_LO=0);
  - per-field mask constants;
  - state enum IDLE/PULSE/WAIT/CAPTURE;
  - op enum GET/SET.
- One combinational sub-module, rtc_bcd_check: 56-bit input; outputs masked 56-bit value and ok.

Test Plan:
- Reset release with refresh_en=0, no requests: all outputs 0 for 10000 cycles; no strobe.
- host_get_req with rtc_out=0x30_45_12_15_03_08_24: rtc_get high 4 cycles. After XFER_CYCLES, host_data matches, host_valid=1, host_err=0, busy drops.
- host_set_req data 0x00_00_00_01_00_01_25, then rtc_out echoes it:
  - rtc_set pulse with rtc_in equal to the data;
  - then an automatic rtc_get;
  - host_data=0x00_00_00_01_00_01_25.
- host_set_req and host_get_req in the same cycle: set issued first; one get follows (merged with read-back); exactly two strobes total.
- Invalid capture, rtc_out hour=0x25 with sec=0x85: host_err=1, host_vl=1, host_data keeps the previous value.
- refresh_en=1 with REFRESH_CYCLES=1000: rtc_get every 1000 cycles while idle. Dropping refresh_en stops strobes; reassert resumes from the held count. Reset asserted during WAIT clears busy and strobes immediately.
